// File: rtl/piece_fall_ctrl_if.sv
// rtl/piece_fall_ctrl_if.sv - spawn, strobe and skyline bundle between game logic and piece_fall_ctrl
// HARD_DROP_EN adds the hard_drop strobe to the bundle.
interface piece_fall_ctrl_if #(
  parameter int MEM_WIDTH = 4,
  parameter int WIDTH     = 8
);
  logic                       spawn_valid;
  logic [WIDTH*4-1:0]         spawn_x;
  logic [WIDTH*4-1:0]         spawn_y;
  logic                       spawn_ready;
  logic                       tick;
  logic                       mv_left;
  logic                       mv_right;
`ifdef HARD_DROP_EN
  logic                       hard_drop;
`endif
  logic [WIDTH*MEM_WIDTH-1:0] cur_bus;
  logic [WIDTH*4-1:0]         new_coord_x_step_3;
  logic [WIDTH*4-1:0]         new_coord_y_step_3;
  logic [WIDTH*MEM_WIDTH-1:0] new_bus_step_3;
  logic                       is_write_mem;
  logic                       busy;
  logic                       game_over;

  modport master (
    output spawn_valid, spawn_x, spawn_y, tick, mv_left, mv_right, cur_bus,
`ifdef HARD_DROP_EN
    output hard_drop,
`endif
    input  spawn_ready, new_coord_x_step_3, new_coord_y_step_3, new_bus_step_3,
    input  is_write_mem, busy, game_over
  );

  modport slave (
    input  spawn_valid, spawn_x, spawn_y, tick, mv_left, mv_right, cur_bus,
`ifdef HARD_DROP_EN
    input  hard_drop,
`endif
    output spawn_ready, new_coord_x_step_3, new_coord_y_step_3, new_bus_step_3,
    output is_write_mem, busy, game_over
  );
endinterface

// File: rtl/piece_fall_ctrl.sv
// rtl/piece_fall_ctrl.sv - active tetromino fall/move/land controller feeding the board memory
// HARD_DROP_EN enables a one-cycle hard drop to the skyline while falling.
module piece_fall_ctrl #(
  parameter int MEM_WIDTH  = 4,
  parameter int MEM_HEIGHT = 4,
  parameter int WIDTH      = 8
) (
  input  logic             clk,
  input  logic             rst,
  piece_fall_ctrl_if.slave pf
);
  typedef enum logic [2:0] {S_IDLE, S_FALL, S_LAND, S_WRITE, S_OVER} state_t;

  localparam logic [WIDTH-1:0] COL_LAST   = WIDTH'(MEM_WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);
  localparam logic [WIDTH:0]   ONE_X      = (WIDTH+1)'(1);
  localparam logic [WIDTH:0]   HEIGHT_MAX = (WIDTH+1)'(MEM_HEIGHT);

  state_t                     state_q;
  logic [WIDTH-1:0]           cx_q [4];
  logic [WIDTH-1:0]           cy_q [4];
  logic [WIDTH*MEM_WIDTH-1:0] bus_q;
  logic                       wr_q;
  logic                       over_q;
  logic                       ready_q;
  logic                       busy_q;

  logic [WIDTH-1:0]           hgt [MEM_WIDTH];
  logic [WIDTH-1:0]           sx [4];
  logic [WIDTH-1:0]           sy [4];
  logic                       spawn_bad, blocked, left_ok, right_ok, land_ovf;
  logic [WIDTH*MEM_WIDTH-1:0] nb_flat;
  logic [WIDTH*4-1:0]         x_flat, y_flat;
`ifdef HARD_DROP_EN
  logic [WIDTH-1:0]           drop_d;
`endif

  // Columns outside the board read as height 0; callers reject those x values separately.
  function automatic logic [WIDTH-1:0] col_h(input logic [WIDTH-1:0] h [MEM_WIDTH],
                                             input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < MEM_WIDTH; i++)
      if (x == WIDTH'(i)) r = h[i];
    return r;
  endfunction

  always_comb begin
    for (int i = 0; i < MEM_WIDTH; i++)
      hgt[i] = pf.cur_bus[WIDTH*(MEM_WIDTH-i)-1 -: WIDTH];
    for (int k = 0; k < 4; k++) begin
      sx[k] = pf.spawn_x[WIDTH*(4-k)-1 -: WIDTH];
      sy[k] = pf.spawn_y[WIDTH*(4-k)-1 -: WIDTH];
    end
  end

  always_comb begin
    spawn_bad = 1'b0;
    blocked   = 1'b0;
    left_ok   = 1'b1;
    right_ok  = 1'b1;
`ifdef HARD_DROP_EN
    drop_d    = '1;
`endif
    for (int k = 0; k < 4; k++) begin
      if (sx[k] > COL_LAST || sy[k] < col_h(hgt, sx[k]))
        spawn_bad = 1'b1;
      if (cy_q[k] == col_h(hgt, cx_q[k]))
        blocked = 1'b1;
      if (cx_q[k] == '0 || cy_q[k] < col_h(hgt, cx_q[k] - ONE))
        left_ok = 1'b0;
      if (cx_q[k] >= COL_LAST || cy_q[k] < col_h(hgt, cx_q[k] + ONE))
        right_ok = 1'b0;
`ifdef HARD_DROP_EN
      if (cy_q[k] - col_h(hgt, cx_q[k]) < drop_d)
        drop_d = cy_q[k] - col_h(hgt, cx_q[k]);
`endif
    end
  end

  // Landed skyline is computed one bit wider so a cell at the top coordinate cannot wrap to 0.
  always_comb begin
    logic [WIDTH:0] nb;
    land_ovf = 1'b0;
    nb_flat  = '0;
    nb       = '0;
    for (int i = 0; i < MEM_WIDTH; i++) begin
      nb = {1'b0, hgt[i]};
      for (int k = 0; k < 4; k++)
        if (cx_q[k] == WIDTH'(i) && ({1'b0, cy_q[k]} + ONE_X) > nb)
          nb = {1'b0, cy_q[k]} + ONE_X;
      if (nb > HEIGHT_MAX)
        land_ovf = 1'b1;
      nb_flat[WIDTH*(MEM_WIDTH-i)-1 -: WIDTH] = nb[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      for (int k = 0; k < 4; k++) begin
        cx_q[k] <= '0;
        cy_q[k] <= '0;
      end
      bus_q   <= '0;
      wr_q    <= 1'b0;
      over_q  <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      wr_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pf.spawn_valid) begin
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            if (spawn_bad) begin
              state_q <= S_OVER;
              over_q  <= 1'b1;
            end else begin
              state_q <= S_FALL;
              for (int k = 0; k < 4; k++) begin
                cx_q[k] <= sx[k];
                cy_q[k] <= sy[k];
              end
            end
          end
        end
        S_FALL: begin
`ifdef HARD_DROP_EN
          if (pf.hard_drop) begin
            for (int k = 0; k < 4; k++) cy_q[k] <= cy_q[k] - drop_d;
            state_q <= S_LAND;
          end else
`endif
          if (pf.tick) begin
            if (blocked) state_q <= S_LAND;
            else for (int k = 0; k < 4; k++) cy_q[k] <= cy_q[k] - ONE;
          end else if (pf.mv_left && !pf.mv_right) begin
            if (left_ok) for (int k = 0; k < 4; k++) cx_q[k] <= cx_q[k] - ONE;
          end else if (pf.mv_right && !pf.mv_left) begin
            if (right_ok) for (int k = 0; k < 4; k++) cx_q[k] <= cx_q[k] + ONE;
          end
        end
        S_LAND: begin
          bus_q <= nb_flat;
          if (land_ovf) begin
            state_q <= S_OVER;
            over_q  <= 1'b1;
          end else begin
            state_q <= S_WRITE;
            wr_q    <= 1'b1;
          end
        end
        S_WRITE: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
        S_OVER: state_q <= S_OVER;
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    x_flat = '0;
    y_flat = '0;
    for (int k = 0; k < 4; k++) begin
      x_flat[WIDTH*(4-k)-1 -: WIDTH] = cx_q[k];
      y_flat[WIDTH*(4-k)-1 -: WIDTH] = cy_q[k];
    end
  end

  assign pf.new_coord_x_step_3 = x_flat;
  assign pf.new_coord_y_step_3 = y_flat;
  assign pf.new_bus_step_3     = bus_q;
  assign pf.is_write_mem       = wr_q;
  assign pf.game_over          = over_q;
  assign pf.spawn_ready        = ready_q;
  assign pf.busy               = busy_q;
endmodule

// File: tb/tb_piece_fall_ctrl.sv
// tb/tb_piece_fall_ctrl.sv - vector table, directed corners and randomized model check for piece_fall_ctrl
module tb_piece_fall_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  piece_fall_ctrl_if #(.MEM_WIDTH(4), .WIDTH(8)) pf_if ();
  piece_fall_ctrl #(.MEM_WIDTH(4), .MEM_HEIGHT(4), .WIDTH(8)) dut (
    .clk(clk), .rst(rst), .pf(pf_if)
  );

  int checks = 0;
  int errors = 0;

  // Reference view of the board: piece cells and skyline as plain integers
  int mx [4];
  int my [4];
  int sky [4];
  int nb [4];

  typedef struct packed {
    logic        t, l, r;
    logic [31:0] ex, ey;
    logic        eb;
  } vec_t;
  vec_t tbl [8];

  int shp_dx [5][4] = '{'{0,1,2,3}, '{0,1,0,1}, '{0,0,0,0}, '{0,0,0,1}, '{0,1,2,1}};
  int shp_dy [5][4] = '{'{0,0,0,0}, '{0,0,1,1}, '{0,1,2,3}, '{0,1,2,0}, '{0,0,0,1}};
  int shp_w  [5]    = '{3, 1, 0, 1, 2};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    pf_if.spawn_valid = 1'b0;
    pf_if.tick        = 1'b0;
    pf_if.mv_left     = 1'b0;
    pf_if.mv_right    = 1'b0;
`ifdef HARD_DROP_EN
    pf_if.hard_drop   = 1'b0;
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic spawn(input logic [31:0] x, input logic [31:0] y);
    pf_if.spawn_x     = x;
    pf_if.spawn_y     = y;
    pf_if.spawn_valid = 1'b1;
    step();
    pf_if.spawn_valid = 1'b0;
  endtask

  task automatic strobe(input logic t, input logic l, input logic r);
    pf_if.tick     = t;
    pf_if.mv_left  = l;
    pf_if.mv_right = r;
    step();
    clr_in();
  endtask

  function automatic logic [31:0] pk(input int a [4]);
    logic [31:0] v;
    v = '0;
    for (int k = 0; k < 4; k++) v[31-8*k -: 8] = 8'(a[k]);
    return v;
  endfunction

  function automatic bit m_blocked();
    for (int k = 0; k < 4; k++) if (my[k] == sky[mx[k]]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_can(input int dx);
    for (int k = 0; k < 4; k++) begin
      if (mx[k] + dx < 0 || mx[k] + dx > 3) return 1'b0;
      if (my[k] < sky[mx[k] + dx]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic bit m_land();
    bit ovf;
    ovf = 1'b0;
    for (int i = 0; i < 4; i++) begin
      nb[i] = sky[i];
      for (int k = 0; k < 4; k++) if (mx[k] == i && my[k] + 1 > nb[i]) nb[i] = my[k] + 1;
      if (nb[i] > 4) ovf = 1'b1;
    end
    return ovf;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit landed, ovf, bad, t, l, r;
    int s, x0, y0;

    clr_in();
    pf_if.cur_bus = '0;
    pf_if.spawn_x = '0;
    pf_if.spawn_y = '0;
    tbl[0] = '{1'b0, 1'b1, 1'b0, 32'h00000101, 32'h02030203, 1'b1};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 32'h01010202, 32'h02030203, 1'b1};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 32'h01010202, 32'h02030203, 1'b1};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 32'h01010202, 32'h01020102, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 32'h02020303, 32'h01020102, 1'b1};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 32'h02020303, 32'h01020102, 1'b1};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 32'h02020303, 32'h00010001, 1'b1};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 32'h02020303, 32'h00010001, 1'b1};

    do_reset();
    chk("rst_ready", pf_if.spawn_ready, 1);
    chk("rst_busy", pf_if.busy, 0);
    chk("rst_wr", pf_if.is_write_mem, 0);
    chk("rst_over", pf_if.game_over, 0);
    chk("rst_x", pf_if.new_coord_x_step_3, 0);
    chk("rst_y", pf_if.new_coord_y_step_3, 0);
    chk("rst_bus", pf_if.new_bus_step_3, 0);

    // Flat I on an empty board
    spawn(32'h00010203, 32'h03030303);
    chk("i_spawn_x", pf_if.new_coord_x_step_3, 32'h00010203);
    chk("i_spawn_busy", pf_if.busy, 1);
    chk("i_spawn_ready", pf_if.spawn_ready, 0);
    for (int n = 1; n <= 4; n++) begin
      strobe(1'b1, 1'b0, 1'b0);
      chk("i_tick_y", pf_if.new_coord_y_step_3, {4{8'(n >= 3 ? 0 : 3 - n)}});
      chk("i_tick_wr", pf_if.is_write_mem, 0);
    end
    step();
    chk("i_write", pf_if.is_write_mem, 1);
    chk("i_bus", pf_if.new_bus_step_3, 32'h01010101);
    step();
    chk("i_wr_off", pf_if.is_write_mem, 0);
    chk("i_ready", pf_if.spawn_ready, 1);
    chk("i_busy", pf_if.busy, 0);

    // O piece on a raised column 0
    pf_if.cur_bus = 32'h02000000;
    spawn(32'h00010001, 32'h05050606);
    for (int n = 0; n < 4; n++) strobe(1'b1, 1'b0, 1'b0);
    chk("o_stop_y", pf_if.new_coord_y_step_3, 32'h02020303);
    chk("o_land_wr", pf_if.is_write_mem, 0);
    step();
    chk("o_write", pf_if.is_write_mem, 1);
    chk("o_bus", pf_if.new_bus_step_3, 32'h04040000);
    step();

    // Lateral move table
    pf_if.cur_bus = 32'h00000000;
    spawn(32'h00000101, 32'h02030203);
    for (int v = 0; v < 8; v++) begin
      strobe(tbl[v].t, tbl[v].l, tbl[v].r);
      chk($sformatf("tbl%0d_x", v), pf_if.new_coord_x_step_3, tbl[v].ex);
      chk($sformatf("tbl%0d_y", v), pf_if.new_coord_y_step_3, tbl[v].ey);
      chk($sformatf("tbl%0d_busy", v), pf_if.busy, tbl[v].eb);
    end
    strobe(1'b1, 1'b1, 1'b0);
    chk("tbl_land_drop", pf_if.new_coord_x_step_3, 32'h02020303);
    chk("tbl_write", pf_if.is_write_mem, 1);
    chk("tbl_bus", pf_if.new_bus_step_3, 32'h00000202);
    step();

    // Reset while in LAND
    spawn(32'h00010203, 32'h00000000);
    strobe(1'b1, 1'b0, 1'b0);
    chk("rl_land_busy", pf_if.busy, 1);
    rst = 1'b1;
    #1;
    chk("rl_wr", pf_if.is_write_mem, 0);
    chk("rl_x", pf_if.new_coord_x_step_3, 0);
    chk("rl_ready", pf_if.spawn_ready, 1);
    step();
    rst = 1'b0;
    step();
    chk("rl_wr_after", pf_if.is_write_mem, 0);
    chk("rl_busy_after", pf_if.busy, 0);
    chk("rl_ready_after", pf_if.spawn_ready, 1);

    // Spawn into an occupied cell
    pf_if.cur_bus = 32'h04000000;
    spawn(32'h00010203, 32'h02050505);
    chk("so_over", pf_if.game_over, 1);
    chk("so_ready", pf_if.spawn_ready, 0);
    chk("so_wr", pf_if.is_write_mem, 0);
    spawn(32'h01010101, 32'h07070707);
    chk("so_sticky", pf_if.game_over, 1);
    chk("so_ready2", pf_if.spawn_ready, 0);
    do_reset();
    chk("so_cleared", pf_if.game_over, 0);

    // Landing above the board height
    spawn(32'h00010203, 32'h04040404);
    chk("lo_accept", pf_if.game_over, 0);
    strobe(1'b1, 1'b0, 1'b0);
    step();
    chk("lo_over", pf_if.game_over, 1);
    chk("lo_wr", pf_if.is_write_mem, 0);
    chk("lo_bus", pf_if.new_bus_step_3, 32'h05050505);
    for (int n = 0; n < 3; n++) begin
      spawn(32'h00010203, 32'h07070707);
      chk("lo_wr_hold", pf_if.is_write_mem, 0);
      chk("lo_ready", pf_if.spawn_ready, 0);
    end
    do_reset();

`ifdef HARD_DROP_EN
    pf_if.cur_bus = '0;
    spawn(32'h00010203, 32'h07070707);
    pf_if.hard_drop = 1'b1;
    step();
    pf_if.hard_drop = 1'b0;
    chk("hd_y", pf_if.new_coord_y_step_3, 32'h00000000);
    chk("hd_wr0", pf_if.is_write_mem, 0);
    step();
    chk("hd_write", pf_if.is_write_mem, 1);
    chk("hd_bus", pf_if.new_bus_step_3, 32'h01010101);
    step();
`endif

    // Randomized pieces against the integer board model
    for (int p = 0; p < 40; p++) begin
      for (int i = 0; i < 4; i++) sky[i] = $urandom_range(0, 3);
      pf_if.cur_bus = pk(sky);
      s  = $urandom_range(0, 4);
      x0 = $urandom_range(0, 3 - shp_w[s]);
      y0 = $urandom_range(1, 7);
      bad = 1'b0;
      for (int k = 0; k < 4; k++) begin
        mx[k] = x0 + shp_dx[s][k];
        my[k] = y0 + shp_dy[s][k];
        if (my[k] < sky[mx[k]]) bad = 1'b1;
      end
      spawn(pk(mx), pk(my));
      if (bad) begin
        chk("rand_spawn_over", pf_if.game_over, 1);
        chk("rand_spawn_wr", pf_if.is_write_mem, 0);
        do_reset();
        continue;
      end
      chk("rand_spawn_x", pf_if.new_coord_x_step_3, pk(mx));
      chk("rand_spawn_y", pf_if.new_coord_y_step_3, pk(my));
      landed = 1'b0;
      for (int c = 0; c < 80 && !landed; c++) begin
        t = (c >= 40) ? 1'b1 : ($urandom_range(0, 2) == 0);
        l = 1'($urandom_range(0, 1));
        r = 1'($urandom_range(0, 1));
        strobe(t, l, r);
        if (t) begin
          if (m_blocked()) landed = 1'b1;
          else for (int k = 0; k < 4; k++) my[k]--;
        end else if (l != r) begin
          if (m_can(l ? -1 : 1)) for (int k = 0; k < 4; k++) mx[k] += (l ? -1 : 1);
        end
        chk("rand_x", pf_if.new_coord_x_step_3, pk(mx));
        chk("rand_y", pf_if.new_coord_y_step_3, pk(my));
        chk("rand_wr_fall", pf_if.is_write_mem, 0);
      end
      if (!landed) chk("rand_land_timeout", 0, 1);
      ovf = m_land();
      step();
      if (ovf) begin
        chk("rand_ovf_over", pf_if.game_over, 1);
        chk("rand_ovf_wr", pf_if.is_write_mem, 0);
        do_reset();
      end else begin
        chk("rand_write", pf_if.is_write_mem, 1);
        chk("rand_bus", pf_if.new_bus_step_3, pk(nb));
        step();
        chk("rand_ready", pf_if.spawn_ready, 1);
        chk("rand_wr_off", pf_if.is_write_mem, 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
